// File: rtl/ft232h_recv_cmd.sv
// ft232h_recv_cmd: FT232H 245-sync RX path; drains host bytes into a local FIFO and parses A5 command frames.
// Define RX_CHKSUM_EN to require a trailing XOR checksum byte per frame.
module ft232h_recv_cmd #(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] HDR_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 60000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ft_rxf_i,
    input  logic [7:0]  ft_adbus_i,
    output logic        ft_oe_o,
    output logic        ft_rd_o,
    input  logic        tx_active_i,
    output logic        rx_busy_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [7:0]  cmd_addr_o,
    output logic [15:0] cmd_data_o,
    output logic [7:0]  err_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {B_IDLE, B_OE_ON, B_READ, B_OE_OFF} bus_t;
    typedef enum logic [2:0] {
        P_HDR, P_ADDR, P_DH, P_DL,
`ifdef RX_CHKSUM_EN
        P_CHK,
`endif
        P_OUT
    } par_t;

    bus_t          bus_st;
    par_t          par_st;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, cnt, free;
    logic [TW-1:0] tmo;
    logic          full, empty, room, push, pop;
    logic [7:0]    byte_in;

    assign cnt     = wr_ptr - rd_ptr;
    assign free    = (AW+1)'(FIFO_DEPTH) - cnt;
    assign room    = free >= (AW+1)'(3);
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = !ft_rd_o && !ft_rxf_i && !full;
    assign pop     = !empty && par_st != P_OUT;
    assign byte_in = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= ft_adbus_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
        end
    end

    // The free>=3 margin absorbs the one extra byte taken while RD# is being released.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus_st    <= B_IDLE;
            ft_oe_o   <= 1'b1;
            ft_rd_o   <= 1'b1;
            rx_busy_o <= 1'b0;
        end else begin
            case (bus_st)
                B_IDLE: if (!ft_rxf_i && !tx_active_i && room) begin
                    bus_st    <= B_OE_ON;
                    ft_oe_o   <= 1'b0;
                    rx_busy_o <= 1'b1;
                end
                B_OE_ON: begin
                    bus_st  <= B_READ;
                    ft_rd_o <= 1'b0;
                end
                B_READ: if (ft_rxf_i || !room) begin
                    bus_st  <= B_OE_OFF;
                    ft_rd_o <= 1'b1;
                end
                B_OE_OFF: begin
                    bus_st    <= B_IDLE;
                    ft_oe_o   <= 1'b1;
                    rx_busy_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            par_st      <= P_HDR;
            cmd_valid_o <= 1'b0;
            cmd_addr_o  <= '0;
            cmd_data_o  <= '0;
            err_cnt_o   <= '0;
            tmo         <= '0;
        end else begin
            tmo <= (pop || par_st == P_HDR || par_st == P_OUT) ? '0 : tmo + 1'b1;
            if (pop) begin
                case (par_st)
                    P_HDR:  if (byte_in == HDR_BYTE) par_st <= P_ADDR;
                    P_ADDR: begin
                        cmd_addr_o <= byte_in;
                        par_st     <= P_DH;
                    end
                    P_DH: begin
                        cmd_data_o[15:8] <= byte_in;
                        par_st           <= P_DL;
                    end
                    P_DL: begin
                        cmd_data_o[7:0] <= byte_in;
`ifdef RX_CHKSUM_EN
                        par_st <= P_CHK;
`else
                        par_st      <= P_OUT;
                        cmd_valid_o <= 1'b1;
`endif
                    end
`ifdef RX_CHKSUM_EN
                    P_CHK: if (byte_in == (cmd_addr_o ^ cmd_data_o[15:8] ^ cmd_data_o[7:0])) begin
                        par_st      <= P_OUT;
                        cmd_valid_o <= 1'b1;
                    end else begin
                        par_st    <= P_HDR;
                        err_cnt_o <= err_cnt_o + {7'd0, err_cnt_o != 8'hFF};
                    end
`endif
                    default: ;
                endcase
            end else if (par_st == P_OUT) begin
                if (cmd_ready_i) begin
                    cmd_valid_o <= 1'b0;
                    par_st      <= P_HDR;
                end
            end else if (par_st != P_HDR && tmo == TW'(TIMEOUT_CYC - 1)) begin
                par_st    <= P_HDR;
                err_cnt_o <= err_cnt_o + {7'd0, err_cnt_o != 8'hFF};
            end
        end
    end
endmodule

// File: tb/tb_ft232h_recv_cmd.sv
// tb_ft232h_recv_cmd: FT232H host model feeding random command frames; a scoreboard checks decoded commands.
module tb_ft232h_recv_cmd;
    logic        clk = 1'b0, rst_n_i = 1'b0, ft_rxf_i = 1'b1, tx_active_i = 1'b0, cmd_ready_i = 1'b0;
    logic [7:0]  ft_adbus_i = 8'h00;
    logic        ft_oe_o, ft_rd_o, rx_busy_o, cmd_valid_o;
    logic [7:0]  cmd_addr_o, err_cnt_o;
    logic [15:0] cmd_data_o;

    ft232h_recv_cmd dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .ft_rxf_i(ft_rxf_i), .ft_adbus_i(ft_adbus_i),
        .ft_oe_o(ft_oe_o), .ft_rd_o(ft_rd_o), .tx_active_i(tx_active_i), .rx_busy_o(rx_busy_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_addr_o(cmd_addr_o),
        .cmd_data_o(cmd_data_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  host_q[$];
    logic [23:0] exp_q[$];
    int          total = 0, bad = 0, exp_err = 0, n;
    bit          take = 1'b0, stall_en = 1'b1, rd_prev = 1'b1, oe_p1 = 1'b1, oe_p2 = 1'b1, oe_low, good;
    logic [7:0]  ra, gb;
    logic [15:0] rdat;
    logic [23:0] e;

    // Host side: the FT232H advances its FIFO on each edge where RD# and RXF# were both low.
    always @(posedge clk) begin
        if (rst_n_i && take && host_q.size() > 0) void'(host_q.pop_front());
        #1;
        ft_rxf_i   = (host_q.size() == 0) || (stall_en && $urandom_range(0, 15) == 0);
        ft_adbus_i = host_q.size() > 0 ? host_q[0] : 8'h00;
    end

    always @(negedge clk) begin
        take = !ft_rd_o && !ft_rxf_i;
        if (rst_n_i && cmd_valid_o && cmd_ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL cmd_unexpected got=%h_%h exp=none", cmd_addr_o, cmd_data_o);
            end else begin
                e = exp_q.pop_front();
                if ({cmd_addr_o, cmd_data_o} !== e) begin
                    bad++;
                    $display("FAIL cmd_word got=%h_%h exp=%h_%h", cmd_addr_o, cmd_data_o, e[23:16], e[15:0]);
                end
            end
        end
        if (rst_n_i && rd_prev && !ft_rd_o) begin
            total++;
            if (!(oe_p1 == 1'b0 && oe_p2 == 1'b1 && ft_oe_o == 1'b0)) begin
                bad++;
                $display("FAIL oe_before_rd got=oe(t-2,t-1,t)=%b%b%b exp=100", oe_p2, oe_p1, ft_oe_o);
            end
        end
        rd_prev = ft_rd_o;
        oe_p2   = oe_p1;
        oe_p1   = ft_oe_o;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic bump_err();
        exp_err = exp_err >= 255 ? 255 : exp_err + 1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input bit ok);
        host_q.push_back(8'hA5);
        host_q.push_back(a);
        host_q.push_back(d[15:8]);
        host_q.push_back(d[7:0]);
`ifdef RX_CHKSUM_EN
        host_q.push_back(ok ? (a ^ d[15:8] ^ d[7:0]) : ~(a ^ d[15:8] ^ d[7:0]));
        if (!ok) bump_err();
        if (ok) exp_q.push_back({a, d});
`else
        exp_q.push_back({a, d});
`endif
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((host_q.size() != 0 || exp_q.size() != 0 || cmd_valid_o) && k < budget) begin
            @(posedge clk);
            #1;
            cmd_ready_i = ($urandom_range(0, 3) != 0);
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL drain_timeout got=host%0d_cmd%0d exp=0_0", host_q.size(), exp_q.size());
        end
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_oe", 32'(ft_oe_o), 1);
        check("rst_rd", 32'(ft_rd_o), 1);
        check("rst_busy", 32'(rx_busy_o), 0);
        check("rst_valid", 32'(cmd_valid_o), 0);
        check("rst_addr_data", {8'h0, cmd_addr_o, cmd_data_o}, 0);
        check("rst_err", 32'(err_cnt_o), 0);
        rst_n_i = 1'b1;

        cmd_ready_i = 1'b1;
        send_frame(8'h03, 16'h1234, 1'b1);
        drain(500);
        check("t1_err", 32'(err_cnt_o), 0);

        host_q.push_back(8'h00);
        host_q.push_back(8'hFF);
        send_frame(8'h07, 16'h0001, 1'b1);
        drain(500);
        check("t3_err", 32'(err_cnt_o), 0);

        for (int i = 0; i < 30; i++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                gb = 8'($urandom_range(0, 255));
                host_q.push_back(gb == 8'hA5 ? 8'h5A : gb);
            end
            ra   = 8'($urandom);
            rdat = 16'($urandom);
            good = $urandom_range(0, 4) != 0;
            send_frame(ra, rdat, good);
        end
        drain(3000);
        check("rand_err", 32'(err_cnt_o), 32'(exp_err));

        cmd_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) send_frame(8'(i + 16), 16'($urandom), 1'b1);
        repeat (500) @(posedge clk);
        #1;
        check("t2_rd_parked", 32'(ft_rd_o), 1);
        check("t2_oe_parked", 32'(ft_oe_o), 1);
        check("t2_valid_held", 32'(cmd_valid_o), 1);
        drain(5000);

        tx_active_i = 1'b1;
        send_frame(8'h42, 16'hBEEF, 1'b1);
        oe_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (!ft_oe_o) oe_low = 1'b1;
        end
        check("t6_tx_block", 32'(oe_low), 0);
        tx_active_i = 1'b0;
        drain(500);

        host_q.push_back(8'hA5);
        host_q.push_back(8'h03);
        bump_err();
        n = 0;
        while (host_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (61000) @(posedge clk);
        #1;
        check("t4_no_cmd", 32'(cmd_valid_o), 0);
        check("t4_err", 32'(err_cnt_o), 32'(exp_err));
        send_frame(8'h55, 16'hA5A5, 1'b1);
        drain(500);
        check("t4_err_after", 32'(err_cnt_o), 32'(exp_err));

`ifdef RX_CHKSUM_EN
        host_q.push_back(8'hA5);
        host_q.push_back(8'h03);
        host_q.push_back(8'h12);
        host_q.push_back(8'h34);
        host_q.push_back(8'h00);
        bump_err();
        drain(500);
        check("t5_bad_chk", 32'(err_cnt_o), 32'(exp_err));
        for (int i = 0; i < 256; i++) send_frame(8'($urandom), 16'($urandom), 1'b0);
        drain(5000);
        check("t5_saturate", 32'(err_cnt_o), 32'hFF);
`endif

        cmd_ready_i = 1'b1;
        stall_en    = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 16'($urandom), 1'b1);
        n = 0;
        while (ft_rd_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_read", 32'(n < 200), 1);
        rst_n_i = 1'b0;
        #1;
        check("t6_rst_rd", 32'(ft_rd_o), 1);
        check("t6_rst_oe", 32'(ft_oe_o), 1);
        check("t6_rst_valid", 32'(cmd_valid_o), 0);
        check("t6_rst_err", 32'(err_cnt_o), 0);
        host_q.delete();
        exp_q.delete();
        exp_err  = 0;
        stall_en = 1'b1;
        @(posedge clk);
        #2;
        rst_n_i = 1'b1;
        send_frame(8'h9C, 16'h0F0F, 1'b1);
        drain(500);
        check("post_rst_err", 32'(err_cnt_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
